// File: rtl/epu_pkg.sv
// Shared types and widths for the EPU requantization engine.
package epu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } epu_state_e;

    localparam int EPU_ADDR_W = 12;
    localparam int EPU_IN_W   = 128;
    localparam int EPU_LANES  = 4;
    localparam int EPU_ACC_W  = 32;
    localparam int EPU_OUT_W  = 8;

endpackage

// File: rtl/epu_requant_lane.sv
// One requantization lane: registered 32x16 product, then combinational
// round / shift / zero-point / ReLU / clamp down to int8.
module epu_requant_lane
    import epu_pkg::*;
#(
    parameter logic signed [15:0] MULT  = 16'sd1,
    parameter int                 SHIFT = 0,
    parameter logic signed [7:0]  ZP    = 8'sd0,
    parameter bit                 RELU  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EPU_ACC_W-1:0] x,
    output logic [EPU_OUT_W-1:0] y
);

    localparam int PROD_W = 48;
    // Rounding constant is zero when no shift is applied.
    localparam logic signed [PROD_W:0] RND =
        (SHIFT > 0) ? (49'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 49'sd0;

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] m_ext;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [PROD_W:0]   rounded;
    logic signed [PROD_W:0]   shifted;
    logic signed [PROD_W+1:0] zp_ext;
    logic signed [PROD_W+1:0] biased;
    logic signed [PROD_W+1:0] relu_val;

    assign x_ext  = {{(PROD_W-EPU_ACC_W){x[EPU_ACC_W-1]}}, x};
    assign m_ext  = {{(PROD_W-16){MULT[15]}}, MULT};
    assign zp_ext = {{(PROD_W+2-8){ZP[7]}}, ZP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
        end else begin
            prod_reg <= x_ext * m_ext;
        end
    end

    always_comb begin
        rounded  = {prod_reg[PROD_W-1], prod_reg} + RND;
        shifted  = rounded >>> SHIFT;
        biased   = {shifted[PROD_W], shifted} + zp_ext;
        relu_val = biased;
        if (RELU && (biased < zp_ext)) begin
            relu_val = zp_ext;
        end
        if (relu_val > 50'sd127) begin
            y = 8'h7F;
        end else if (relu_val < -50'sd128) begin
            y = 8'h80;
        end else begin
            y = relu_val[EPU_OUT_W-1:0];
        end
    end

endmodule

// File: rtl/epu_requant_engine.sv
// Streams int32x4 words from the input SRAM, requantizes each lane to int8
// and writes one packed word per input word to the output SRAM.
module epu_requant_engine
    import epu_pkg::*;
#(
    parameter int                 NUM_WORDS = 1024,
    parameter logic signed [15:0] MULT      = 16'sd1,
    parameter int                 SHIFT     = 0,
    parameter logic signed [7:0]  ZP        = 8'sd0,
    parameter bit                 RELU      = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           start_signal_s7,
    input  logic [EPU_IN_W-1:0]            DO_s7,
    output logic [EPU_ADDR_W-1:0]          A_s7,
    input  logic                           start_signal_s8,
    output logic [EPU_ADDR_W-1:0]          A_s8,
    output logic [EPU_LANES-1:0]           WEB_s8,
    output logic [EPU_LANES*EPU_OUT_W-1:0] DI_s8,
    output logic                           end_signal
);

    generate
        if (NUM_WORDS < 1 || NUM_WORDS > (1 << EPU_ADDR_W)) begin : g_bad_num_words
            $error("epu_requant_engine: NUM_WORDS must be in 1..4096");
        end
        if (SHIFT < 0 || SHIFT > 31) begin : g_bad_shift
            $error("epu_requant_engine: SHIFT must be in 0..31");
        end
    endgenerate

    localparam logic [EPU_ADDR_W:0] LAST_PTR = (EPU_ADDR_W+1)'(NUM_WORDS);

    epu_state_e                     state;
    logic [EPU_ADDR_W:0]            rd_ptr;
    logic [EPU_ADDR_W-1:0]          wr_ptr;
    // addr_vld: A_s7 carries a live read; data_vld: DO_s7 is live; prod_vld: lane products live.
    logic                           addr_vld;
    logic                           data_vld;
    logic                           prod_vld;
    logic [EPU_LANES*EPU_OUT_W-1:0] packed_res;
    logic                           both_start;

    assign both_start = start_signal_s7 && start_signal_s8;

    genvar gi;
    generate
        for (gi = 0; gi < EPU_LANES; gi++) begin : g_lane
            epu_requant_lane #(
                .MULT  (MULT),
                .SHIFT (SHIFT),
                .ZP    (ZP),
                .RELU  (RELU)
            ) u_lane (
                .clk   (CLK),
                .rst_n (RSTn),
                .x     (DO_s7[EPU_ACC_W*gi +: EPU_ACC_W]),
                .y     (packed_res[EPU_OUT_W*gi +: EPU_OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            addr_vld   <= 1'b0;
            data_vld   <= 1'b0;
            prod_vld   <= 1'b0;
            A_s7       <= '0;
            A_s8       <= '0;
            WEB_s8     <= 4'hF;
            DI_s8      <= '0;
            end_signal <= 1'b0;
        end else begin
            WEB_s8 <= 4'hF;
            case (state)
                IDLE: begin
                    addr_vld <= 1'b0;
                    data_vld <= 1'b0;
                    prod_vld <= 1'b0;
                    if (both_start) begin
                        state    <= RUN;
                        A_s7     <= '0;
                        rd_ptr   <= (EPU_ADDR_W+1)'(1);
                        wr_ptr   <= '0;
                        addr_vld <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (!both_start) begin
                        // Abort: drop everything in flight; completed writes stay.
                        state    <= IDLE;
                        addr_vld <= 1'b0;
                        data_vld <= 1'b0;
                        prod_vld <= 1'b0;
                    end else begin
                        data_vld <= addr_vld;
                        prod_vld <= data_vld;
                        if (prod_vld) begin
                            WEB_s8 <= 4'h0;
                            A_s8   <= wr_ptr;
                            DI_s8  <= packed_res;
                            wr_ptr <= wr_ptr + 12'd1;
                        end
                        if (state == RUN) begin
                            if (rd_ptr == LAST_PTR) begin
                                state    <= DRAIN;
                                addr_vld <= 1'b0;
                            end else begin
                                A_s7     <= rd_ptr[EPU_ADDR_W-1:0];
                                rd_ptr   <= rd_ptr + 13'd1;
                                addr_vld <= 1'b1;
                            end
                        end else if (!addr_vld && !data_vld && !prod_vld) begin
                            state      <= DONE;
                            end_signal <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_signal_s7 && !start_signal_s8) begin
                        state      <= IDLE;
                        end_signal <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epu_requant_engine.sv
// Directed bench for epu_requant_engine: three parameterizations, each with
// its own SRAM model and write monitor.
module tb_epu_requant_engine;
    import epu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] word4(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    // Instance A: N=4, MULT=1, SHIFT=0, ZP=0, RELU=0
    logic rstn_a = 1'b1, s7_a = 1'b0, s8_a = 1'b0, end_a;
    logic [127:0] do_a;
    logic [11:0]  a7_a, a8_a;
    logic [3:0]   web_a;
    logic [31:0]  di_a;
    logic [127:0] mem_a [4096];
    always @(posedge clk) do_a <= mem_a[a7_a];

    epu_requant_engine #(.NUM_WORDS(4), .MULT(16'sd1), .SHIFT(0), .ZP(8'sd0), .RELU(1'b0)) u_a (
        .CLK(clk), .RSTn(rstn_a), .start_signal_s7(s7_a), .DO_s7(do_a), .A_s7(a7_a),
        .start_signal_s8(s8_a), .A_s8(a8_a), .WEB_s8(web_a), .DI_s8(di_a), .end_signal(end_a));

    // Instance B: N=1, MULT=1, SHIFT=0, ZP=0, RELU=1
    logic rstn_b = 1'b1, s7_b = 1'b0, s8_b = 1'b0, end_b;
    logic [127:0] do_b;
    logic [11:0]  a7_b, a8_b;
    logic [3:0]   web_b;
    logic [31:0]  di_b;
    logic [127:0] mem_b [4096];
    always @(posedge clk) do_b <= mem_b[a7_b];

    epu_requant_engine #(.NUM_WORDS(1), .MULT(16'sd1), .SHIFT(0), .ZP(8'sd0), .RELU(1'b1)) u_b (
        .CLK(clk), .RSTn(rstn_b), .start_signal_s7(s7_b), .DO_s7(do_b), .A_s7(a7_b),
        .start_signal_s8(s8_b), .A_s8(a8_b), .WEB_s8(web_b), .DI_s8(di_b), .end_signal(end_b));

    // Instance C: N=2, MULT=3, SHIFT=2, ZP=10, RELU=0
    logic rstn_c = 1'b1, s7_c = 1'b0, s8_c = 1'b0, end_c;
    logic [127:0] do_c;
    logic [11:0]  a7_c, a8_c;
    logic [3:0]   web_c;
    logic [31:0]  di_c;
    logic [127:0] mem_c [4096];
    always @(posedge clk) do_c <= mem_c[a7_c];

    epu_requant_engine #(.NUM_WORDS(2), .MULT(16'sd3), .SHIFT(2), .ZP(8'sd10), .RELU(1'b0)) u_c (
        .CLK(clk), .RSTn(rstn_c), .start_signal_s7(s7_c), .DO_s7(do_c), .A_s7(a7_c),
        .start_signal_s8(s8_c), .A_s8(a8_c), .WEB_s8(web_c), .DI_s8(di_c), .end_signal(end_c));

    // Write / end_signal monitors, sampled on the falling edge.
    int wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
    logic [11:0] wa_a [64], wa_b [64], wa_c [64];
    logic [31:0] wd_a [64], wd_b [64], wd_c [64];
    int wc_a [64], wc_b [64], wc_c [64];
    int end_cyc_a = -1, end_cyc_b = -1, end_cyc_c = -1;
    logic end_q_a = 1'b0, end_q_b = 1'b0, end_q_c = 1'b0;

    always @(negedge clk) begin
        if (web_a == 4'h0 && wr_cnt_a < 64) begin
            wa_a[wr_cnt_a] = a8_a; wd_a[wr_cnt_a] = di_a; wc_a[wr_cnt_a] = cyc;
            $display("write a addr=%0d data=%h cyc=%0d", a8_a, di_a, cyc);
            wr_cnt_a++;
        end
        if (web_b == 4'h0 && wr_cnt_b < 64) begin
            wa_b[wr_cnt_b] = a8_b; wd_b[wr_cnt_b] = di_b; wc_b[wr_cnt_b] = cyc;
            $display("write b addr=%0d data=%h cyc=%0d", a8_b, di_b, cyc);
            wr_cnt_b++;
        end
        if (web_c == 4'h0 && wr_cnt_c < 64) begin
            wa_c[wr_cnt_c] = a8_c; wd_c[wr_cnt_c] = di_c; wc_c[wr_cnt_c] = cyc;
            $display("write c addr=%0d data=%h cyc=%0d", a8_c, di_c, cyc);
            wr_cnt_c++;
        end
        if (end_a && !end_q_a) end_cyc_a = cyc;
        if (end_b && !end_q_b) end_cyc_b = cyc;
        if (end_c && !end_q_c) end_cyc_c = cyc;
        end_q_a = end_a;
        end_q_b = end_b;
        end_q_c = end_c;
    end

    logic [31:0] exp_a [4];

    // Full 4-word run on instance A: addresses, data, write timing and end latency.
    task automatic check_run_a(input string tag, input int base, input int cs);
        check({tag, "_wr_count"}, 32'(wr_cnt_a - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(wa_a[base + k]), 32'(k));
            check($sformatf("%s_data%0d", tag, k), wd_a[base + k], exp_a[k]);
            check($sformatf("%s_wcyc%0d", tag, k), 32'(wc_a[base + k] - cs), 32'(3 + k));
        end
        check({tag, "_end_lat"}, 32'(end_cyc_a - cs), 32'd7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cs;
        int base;
        int viol;
        logic [11:0] a_hold;

        mem_a[0] = word4(5, -3, 127, -128);
        mem_a[1] = word4(1, 2, 3, 4);
        mem_a[2] = word4(-1, -2, 200, -200);
        mem_a[3] = word4(5, -3, 127, -128);
        exp_a[0] = 32'h807FFD05;
        exp_a[1] = 32'h04030201;
        exp_a[2] = 32'h807FFEFF;
        exp_a[3] = 32'h807FFD05;
        mem_b[0] = word4(300, -300, 128, -1);
        mem_c[0] = word4(5, 6, -5, 0);
        mem_c[1] = word4(-6, 2, 1000, -1000);

        #2;
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        #1;
        check("rst_web", 32'(web_a), 32'hF);
        check("rst_a7", 32'(a7_a), 32'd0);
        check("rst_a8", 32'(a8_a), 32'd0);
        check("rst_di", di_a, 32'd0);
        check("rst_end", 32'(end_a), 32'd0);
        tick(); tick();
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        tick(); tick();
        check("rst_idle", 32'(u_a.state), 32'(IDLE));

        // Plain passthrough run
        s7_a = 1'b1; s8_a = 1'b1;
        cs = cyc + 1; base = wr_cnt_a;
        for (int i = 0; i < 40 && end_a !== 1'b1; i++) tick();
        check("t2_end_seen", 32'(end_a), 32'd1);
        check_run_a("t2", base, cs);

        // Starts held high in DONE: no re-trigger, no traffic
        a_hold = a7_a; base = wr_cnt_a; viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (end_a !== 1'b1 || web_a !== 4'hF || a7_a !== a_hold) viol++;
        end
        check("t6_hold_viol", 32'(viol), 32'd0);
        check("t6_no_writes", 32'(wr_cnt_a - base), 32'd0);
        s7_a = 1'b0; s8_a = 1'b0;
        tick();
        check("t6_end_low", 32'(end_a), 32'd0);
        check("t6_idle", 32'(u_a.state), 32'(IDLE));

        // Abort while the first write is on the bus
        s7_a = 1'b1; s8_a = 1'b1;
        cs = cyc + 1; base = wr_cnt_a;
        for (int i = 0; i < 10 && cyc < cs + 3; i++) tick();
        s8_a = 1'b0;
        tick();
        check("t5_web", 32'(web_a), 32'hF);
        check("t5_end", 32'(end_a), 32'd0);
        check("t5_wr_count", 32'(wr_cnt_a - base), 32'd1);
        check("t5_idle", 32'(u_a.state), 32'(IDLE));
        for (int i = 0; i < 10; i++) tick();
        check("t5_quiet_wr", 32'(wr_cnt_a - base), 32'd1);
        check("t5_quiet_end", 32'(end_a), 32'd0);
        s8_a = 1'b1;
        cs = cyc + 1; base = wr_cnt_a;
        for (int i = 0; i < 40 && end_a !== 1'b1; i++) tick();
        check("t5r_end_seen", 32'(end_a), 32'd1);
        check_run_a("t5r", base, cs);
        s7_a = 1'b0; s8_a = 1'b0;
        tick(); tick();

        // Async reset while word 1 is being written
        s7_a = 1'b1; s8_a = 1'b1;
        cs = cyc + 1;
        for (int i = 0; i < 10 && cyc < cs + 4; i++) tick();
        check("t1_pre_web", 32'(web_a), 32'h0);
        rstn_a = 1'b0;
        #1;
        check("t1_web", 32'(web_a), 32'hF);
        check("t1_a7", 32'(a7_a), 32'd0);
        check("t1_end", 32'(end_a), 32'd0);
        check("t1_di", di_a, 32'd0);
        s7_a = 1'b0; s8_a = 1'b0;
        base = wr_cnt_a;
        tick(); tick(); tick();
        rstn_a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t1_no_writes", 32'(wr_cnt_a - base), 32'd0);
        check("t1_idle", 32'(u_a.state), 32'(IDLE));
        check("t1_a7_idle", 32'(a7_a), 32'd0);

        // NUM_WORDS=1 with saturation and ReLU
        s7_b = 1'b1; s8_b = 1'b1;
        cs = cyc + 1; base = wr_cnt_b;
        for (int i = 0; i < 40 && end_b !== 1'b1; i++) tick();
        check("t3_end_seen", 32'(end_b), 32'd1);
        check("t3_wr_count", 32'(wr_cnt_b - base), 32'd1);
        check("t3_addr", 32'(wa_b[base]), 32'd0);
        check("t3_data", wd_b[base], 32'h007F007F);
        check("t3_wcyc", 32'(wc_b[base] - cs), 32'd3);
        check("t3_end_lat", 32'(end_cyc_b - cs), 32'd4);
        s7_b = 1'b0; s8_b = 1'b0;
        tick();
        check("t3_end_low", 32'(end_b), 32'd0);

        // Rounding: MULT=3, SHIFT=2, ZP=10.
        // w0: 15+2>>>2=4, 18+2>>>2=5, -15+2=-13>>>2=-4, 0 -> 0E,0F,06,0A
        // w1: -18+2>>>2=-4, 6+2>>>2=2, 3002>>>2=750, -2998>>>2=-750 -> 06,0C,7F,80
        s7_c = 1'b1; s8_c = 1'b1;
        cs = cyc + 1; base = wr_cnt_c;
        for (int i = 0; i < 40 && end_c !== 1'b1; i++) tick();
        check("t4_end_seen", 32'(end_c), 32'd1);
        check("t4_wr_count", 32'(wr_cnt_c - base), 32'd2);
        check("t4_addr0", 32'(wa_c[base]), 32'd0);
        check("t4_data0", wd_c[base], 32'h0A060F0E);
        check("t4_addr1", 32'(wa_c[base + 1]), 32'd1);
        check("t4_data1", wd_c[base + 1], 32'h807F0C06);
        check("t4_end_lat", 32'(end_cyc_c - cs), 32'd5);
        s7_c = 1'b0; s8_c = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
